// File: rtl/demux_1_8_v_cmpnt.sv
// demux_1_8_v_cmpnt: registered 1:8 demux built from a tree of 1:2 cells.
// Define DEMUX_SEL_CHECK_EN to add o_sel_err and the reserved-select-bit check.
module demux_1_8_v_cmpnt #(
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_a,
    input  logic [7:0] i_sel_code,
`ifdef DEMUX_SEL_CHECK_EN
    output logic       o_sel_err,
`endif
    output logic [7:0] o_code
);
    logic [1:0] l1;
    logic [3:0] l2;
    logic [7:0] l3;
    // Each 1:2 cell passes its input to the selected branch and idles the other.
    assign l1[0] = i_sel_code[2] ? IDLE_LEVEL : i_a;
    assign l1[1] = i_sel_code[2] ? i_a : IDLE_LEVEL;
    for (genvar j = 0; j < 2; j++) begin : g_l2
        assign l2[2*j]   = i_sel_code[1] ? IDLE_LEVEL : l1[j];
        assign l2[2*j+1] = i_sel_code[1] ? l1[j] : IDLE_LEVEL;
    end
    for (genvar j = 0; j < 4; j++) begin : g_l3
        assign l3[2*j]   = i_sel_code[0] ? IDLE_LEVEL : l2[j];
        assign l3[2*j+1] = i_sel_code[0] ? l2[j] : IDLE_LEVEL;
    end
`ifdef DEMUX_SEL_CHECK_EN
    logic sel_err;
    assign sel_err = |i_sel_code[7:3];
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_code    <= {8{IDLE_LEVEL}};
            o_sel_err <= 1'b0;
        end else begin
            o_code    <= sel_err ? {8{IDLE_LEVEL}} : l3;
            o_sel_err <= sel_err;
        end
    end
`else
    logic unused_sel;
    assign unused_sel = ^i_sel_code[7:3];
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) o_code <= {8{IDLE_LEVEL}};
        else          o_code <= l3;
    end
`endif
endmodule

// File: tb/tb_demux_1_8_v_cmpnt.sv
// tb_demux_1_8_v_cmpnt: scoreboard bench for the registered 1:8 demux.
module tb_demux_1_8_v_cmpnt;
    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_a = 1'b0;
    logic [7:0] i_sel_code = 8'h00;
    logic [7:0] o_code;
    logic [8:0] q[$];
    int         errors = 0;
    int         checks = 0;
`ifdef DEMUX_SEL_CHECK_EN
    logic       o_sel_err;
    demux_1_8_v_cmpnt dut (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_a(i_a), .i_sel_code(i_sel_code),
                           .o_sel_err(o_sel_err), .o_code(o_code));
    function automatic logic [8:0] observed();
        return {o_sel_err, o_code};
    endfunction
    function automatic logic [8:0] model(input logic a, input logic [7:0] sel);
        logic [7:0] c;
        c = 8'h00;
        c[sel[2:0]] = a;
        return (|sel[7:3]) ? 9'h100 : {1'b0, c};
    endfunction
`else
    demux_1_8_v_cmpnt dut (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_a(i_a), .i_sel_code(i_sel_code),
                           .o_code(o_code));
    function automatic logic [8:0] observed();
        return {1'b0, o_code};
    endfunction
    function automatic logic [8:0] model(input logic a, input logic [7:0] sel);
        logic [7:0] c;
        c = 8'h00;
        c[sel[2:0]] = a;
        return {1'b0, c};
    endfunction
`endif
    always #5 i_clk = ~i_clk;
    task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got err/code=%h expected %h", tag, got, exp);
        end
    endtask
    task automatic drive(input string tag, input logic a, input logic [7:0] sel);
        logic [8:0] exp;
        i_a = a;
        i_sel_code = sel;
        q.push_back(model(a, sel));
        @(posedge i_clk);
        #1;
        if (q.size() == 0) chk({tag, "_empty"}, observed(), 9'h1ff);
        else begin
            exp = q.pop_front();
            chk(tag, observed(), exp);
        end
    endtask
    initial begin
        for (int i = 0; i < 4; i++) begin
            i_a = i[0];
            i_sel_code = 8'(i * 37);
            @(posedge i_clk);
            #1;
            chk("reset_hold", observed(), 9'h000);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        #1;
        for (int k = 0; k < 8; k++) drive("walk", 1'b1, 8'(k));
        drive("data_zero", 1'b0, 8'h05);
        drive("reserved", 1'b1, 8'h0B);
        drive("reserved_hi", 1'b1, 8'hF8);
        for (int c = 0; c <= 256; c++) begin
            logic [8:0] v;
            v = 9'(c);
            drive("sweep", v[0], v[8:1]);
            if (c == 100) begin
                i_a = 1'b1;
                i_sel_code = 8'h06;
                #3;
                i_rst_n = 1'b0;
                #1;
                chk("async_clear", observed(), 9'h000);
                @(posedge i_clk);
                #1;
                chk("reset_mid_hold", observed(), 9'h000);
                #2;
                i_rst_n = 1'b1;
                @(posedge i_clk);
                #1;
                chk("first_after_release", observed(), model(1'b1, 8'h06));
            end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
